// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE adder controller.
//   state_t   : controller FSM states, one transition per completed handshake
//   SEL_ACCUM : SEL code for accumulate (acc + product)
//   SEL_PSUM  : SEL code for psum-out (neighbour psum + acc)
package pe_ctrl_pkg;

  typedef enum logic [3:0] {
    S_GET_PROD,
    S_SEL_ACC,
    S_OP_ACC,
    S_WAIT_ACC,
    S_GET_PSUM,
    S_SEL_OUT,
    S_OP_OUT,
    S_WAIT_OUT,
    S_EMIT
  } state_t;

  localparam logic [1:0] SEL_ACCUM = 2'b01;
  localparam logic [1:0] SEL_PSUM  = 2'b10;

endpackage

// File: rtl/pe_pair_issue.sv
// Issues two operands in parallel on independent valid/ready channels.
//   clk, rst_n            : clock, synchronous active-low reset
//   load_i                : raise both valids on the next edge
//   a_ready_i, b_ready_i  : peer readies for the two channels
//   a_valid_o, b_valid_o  : registered valids, each drops on its own transfer
//   done_o                : the last outstanding operand transfers this cycle
module pe_pair_issue (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic a_ready_i,
  input  logic b_ready_i,
  output logic a_valid_o,
  output logic b_valid_o,
  output logic done_o
);

  logic a_q, a_d;
  logic b_q, b_d;

  // NOTE: every always_comb target gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    a_d = a_q & ~a_ready_i;
    b_d = b_q & ~b_ready_i;
    if (load_i) begin
      a_d = 1'b1;
      b_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign a_valid_o = a_q;
  assign b_valid_o = b_q;
  // Something was outstanding and nothing will be after this edge; covers
  // either transfer order as well as both in the same cycle.
  assign done_o    = (a_q | b_q) & ~a_d & ~b_d;

endmodule

// File: rtl/pe_adder_ctrl.sv
// Clocked driver for the PE adder channel set. Per output window it
// accumulates NUM_MACS multiplier products through the adder (SEL=01),
// merges the neighbour partial sum (SEL=10) and emits the merged result.
//   prod_*      : product input channel (WIDTH)
//   psum_in_*   : neighbour partial-sum input channel (WIDTH)
//   sel_*       : SEL code to the adder
//   a0_*, a1_*, b0_* : adder operands (WIDTH)
//   r_*         : adder result (WIDTH+2)
//   psum_out_*  : window result (WIDTH+2)
//   busy        : a window is in progress
//   overflow    : sticky, an accumulate result did not fit in WIDTH bits
module pe_adder_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_MACS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [WIDTH-1:0] prod_data,
  input  logic             psum_in_valid,
  output logic             psum_in_ready,
  input  logic [WIDTH-1:0] psum_in_data,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic [1:0]       sel_data,
  output logic             a0_valid,
  input  logic             a0_ready,
  output logic [WIDTH-1:0] a0_data,
  output logic             a1_valid,
  input  logic             a1_ready,
  output logic [WIDTH-1:0] a1_data,
  output logic             b0_valid,
  input  logic             b0_ready,
  output logic [WIDTH-1:0] b0_data,
  input  logic             r_valid,
  output logic             r_ready,
  input  logic [WIDTH+1:0] r_data,
  output logic             psum_out_valid,
  input  logic             psum_out_ready,
  output logic [WIDTH+1:0] psum_out_data,
  output logic             busy,
  output logic             overflow
);

  localparam int CNT_W = $clog2(NUM_MACS + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH+1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Handshake outputs are flops loaded from the next state, so they are 0
  // straight out of reset and never depend combinationally on a peer valid.
  logic prod_ready_q, psum_in_ready_q, sel_valid_q, r_ready_q, out_valid_q;

  logic pair_load, pair_a_valid, pair_b_valid, pair_done, pair_a_ready;

  assign pair_a_ready = (state_q == S_OP_ACC) ? a0_ready : a1_ready;

  pe_pair_issue u_pair (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (pair_load),
    .a_ready_i (pair_a_ready),
    .b_ready_i (b0_ready),
    .a_valid_o (pair_a_valid),
    .b_valid_o (pair_b_valid),
    .done_o    (pair_done)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    psum_d    = psum_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    pair_load = 1'b0;
    unique case (state_q)
      S_GET_PROD: if (prod_valid && prod_ready_q) begin
        prod_d  = prod_data;
        state_d = S_SEL_ACC;
      end
      S_SEL_ACC: if (sel_ready && sel_valid_q) begin
        pair_load = 1'b1;
        state_d   = S_OP_ACC;
      end
      S_OP_ACC: if (pair_done) state_d = S_WAIT_ACC;
      S_WAIT_ACC: if (r_valid && r_ready_q) begin
        // Feedback keeps WIDTH bits; anything above is flagged, not kept.
        acc_d = r_data[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (r_data[WIDTH+1:WIDTH] != 2'b00) ovf_d = 1'b1;
        state_d = (cnt_q == CNT_W'(NUM_MACS - 1)) ? S_GET_PSUM : S_GET_PROD;
      end
      S_GET_PSUM: if (psum_in_valid && psum_in_ready_q) begin
        psum_d  = psum_in_data;
        state_d = S_SEL_OUT;
      end
      S_SEL_OUT: if (sel_ready && sel_valid_q) begin
        pair_load = 1'b1;
        state_d   = S_OP_OUT;
      end
      S_OP_OUT: if (pair_done) state_d = S_WAIT_OUT;
      S_WAIT_OUT: if (r_valid && r_ready_q) begin
        result_d = r_data;
        state_d  = S_EMIT;
      end
      S_EMIT: if (psum_out_ready && out_valid_q) begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_GET_PROD;
      end
      default: state_d = S_GET_PROD;
    endcase
  end

  // NOTE: operand/result holding registers are reset along with the FSM so
  // the data outputs read 0 after reset instead of stale values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_GET_PROD;
      acc_q           <= '0;
      prod_q          <= '0;
      psum_q          <= '0;
      result_q        <= '0;
      cnt_q           <= '0;
      ovf_q           <= 1'b0;
      prod_ready_q    <= 1'b0;
      psum_in_ready_q <= 1'b0;
      sel_valid_q     <= 1'b0;
      r_ready_q       <= 1'b0;
      out_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      prod_q          <= prod_d;
      psum_q          <= psum_d;
      result_q        <= result_d;
      cnt_q           <= cnt_d;
      ovf_q           <= ovf_d;
      prod_ready_q    <= (state_d == S_GET_PROD);
      psum_in_ready_q <= (state_d == S_GET_PSUM);
      sel_valid_q     <= (state_d == S_SEL_ACC) || (state_d == S_SEL_OUT);
      r_ready_q       <= (state_d == S_WAIT_ACC) || (state_d == S_WAIT_OUT);
      out_valid_q     <= (state_d == S_EMIT);
    end
  end

  assign prod_ready     = prod_ready_q;
  assign psum_in_ready  = psum_in_ready_q;
  assign sel_valid      = sel_valid_q;
  assign r_ready        = r_ready_q;
  assign psum_out_valid = out_valid_q;

  assign sel_data = (state_q == S_SEL_ACC) ? SEL_ACCUM :
                    (state_q == S_SEL_OUT) ? SEL_PSUM  : 2'b00;

  // The shared pair issuer feeds A0 during accumulate and A1 during merge.
  assign a0_valid = pair_a_valid && (state_q == S_OP_ACC);
  assign a1_valid = pair_a_valid && (state_q == S_OP_OUT);
  assign b0_valid = pair_b_valid;

  assign a0_data = (state_q == S_OP_ACC) ? acc_q  : '0;
  assign a1_data = (state_q == S_OP_OUT) ? psum_q : '0;
  assign b0_data = (state_q == S_OP_ACC) ? prod_q :
                   (state_q == S_OP_OUT) ? acc_q  : '0;

  assign psum_out_data = (state_q == S_EMIT) ? result_q : '0;

  assign busy     = (state_q != S_GET_PROD) || (cnt_q != '0);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pe_adder_ctrl.sv
module tb_pe_adder_ctrl;
  localparam int WIDTH    = 8;
  localparam int NUM_MACS = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic prod_valid, prod_ready, psum_in_valid, psum_in_ready;
  logic [WIDTH-1:0] prod_data, psum_in_data;
  logic sel_valid, sel_ready;
  logic [1:0] sel_data;
  logic a0_valid, a0_ready, a1_valid, a1_ready, b0_valid, b0_ready;
  logic [WIDTH-1:0] a0_data, a1_data, b0_data;
  logic r_valid, r_ready;
  logic [WIDTH+1:0] r_data;
  logic psum_out_valid, psum_out_ready;
  logic [WIDTH+1:0] psum_out_data;
  logic busy, overflow;

  always #5 clk = ~clk;

  pe_adder_ctrl #(.WIDTH(WIDTH), .NUM_MACS(NUM_MACS)) dut (
    .clk(clk), .rst_n(rst_n),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_data(sel_data),
    .a0_valid(a0_valid), .a0_ready(a0_ready), .a0_data(a0_data),
    .a1_valid(a1_valid), .a1_ready(a1_ready), .a1_data(a1_data),
    .b0_valid(b0_valid), .b0_ready(b0_ready), .b0_data(b0_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready),
    .psum_out_data(psum_out_data),
    .busy(busy), .overflow(overflow)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Producer queues, transfer logs and expectations
  int prod_qu[$], psum_qu[$];
  int sel_log[$], a0_log[$], a1_log[$], b0_log[$], out_log[$];
  int exp_sel[$], exp_a0[$], exp_a1[$], exp_b0[$], exp_out[$];
  bit model_ovf;

  // Peer behaviour knobs, written only by the main sequence
  bit sel_hold = 0, a0_hold = 0, b_force = 0, r_hold = 0, out_hold = 0;
  int proto_err = 0;

  function automatic bit rnd();
    return $urandom_range(0, 3) != 0;
  endfunction

  // Peers: producers, adder model (R = A + B after 1-3 cycles), consumer.
  initial begin : peers
    bit in_rst, f_prod, f_psum, f_sel, f_a0, f_a1, f_b0, f_r, f_out;
    bit have_sel, have_a, have_b;
    int a_v, b_v, r_wait;
    logic [WIDTH-1:0] sa0, sa1, sb0;
    bit p_sel_v, p_sel_f, p_a0_v, p_a0_f, p_b0_v, p_b0_f, p_out_v, p_out_f;
    logic [1:0] p_sel_d;
    logic [WIDTH-1:0] p_a0_d, p_b0_d;
    logic [WIDTH+1:0] p_out_d;
    have_sel = 0; have_a = 0; have_b = 0; a_v = 0; b_v = 0; r_wait = -1;
    p_sel_v = 0; p_sel_f = 0; p_a0_v = 0; p_a0_f = 0;
    p_b0_v = 0; p_b0_f = 0; p_out_v = 0; p_out_f = 0;
    p_sel_d = 0; p_a0_d = 0; p_b0_d = 0; p_out_d = 0;
    prod_valid = 0; prod_data = 0; psum_in_valid = 0; psum_in_data = 0;
    sel_ready = 0; a0_ready = 0; a1_ready = 0; b0_ready = 0;
    r_valid = 0; r_data = 0; psum_out_ready = 0;
    forever begin
      @(negedge clk);
      in_rst = !rst_n;
      f_prod = !in_rst && prod_valid && prod_ready;
      f_psum = !in_rst && psum_in_valid && psum_in_ready;
      f_sel  = !in_rst && sel_valid && sel_ready;
      f_a0   = !in_rst && a0_valid && a0_ready;
      f_a1   = !in_rst && a1_valid && a1_ready;
      f_b0   = !in_rst && b0_valid && b0_ready;
      f_r    = !in_rst && r_valid && r_ready;
      f_out  = !in_rst && psum_out_valid && psum_out_ready;
      sa0 = a0_data; sa1 = a1_data; sb0 = b0_data;
      if (f_sel) sel_log.push_back(int'(sel_data));
      if (f_a0)  a0_log.push_back(int'(a0_data));
      if (f_a1)  a1_log.push_back(int'(a1_data));
      if (f_b0)  b0_log.push_back(int'(b0_data));
      if (f_out) out_log.push_back(int'(psum_out_data));
      // Offered valid/data must hold until taken
      if (!in_rst) begin
        if (p_sel_v && !p_sel_f && (!sel_valid || sel_data != p_sel_d)) proto_err++;
        if (p_a0_v && !p_a0_f && (!a0_valid || a0_data != p_a0_d)) proto_err++;
        if (p_b0_v && !p_b0_f && (!b0_valid || b0_data != p_b0_d)) proto_err++;
        if (p_out_v && !p_out_f && (!psum_out_valid || psum_out_data != p_out_d)) proto_err++;
      end
      p_sel_v = !in_rst && sel_valid;      p_sel_f = f_sel; p_sel_d = sel_data;
      p_a0_v  = !in_rst && a0_valid;       p_a0_f  = f_a0;  p_a0_d  = a0_data;
      p_b0_v  = !in_rst && b0_valid;       p_b0_f  = f_b0;  p_b0_d  = b0_data;
      p_out_v = !in_rst && psum_out_valid; p_out_f = f_out; p_out_d = psum_out_data;

      @(posedge clk);
      #1;
      if (in_rst) begin
        have_sel = 0; have_a = 0; have_b = 0; r_wait = -1;
        r_valid = 0; r_data = 0; prod_valid = 0; psum_in_valid = 0;
      end else begin
        if (f_prod) begin void'(prod_qu.pop_front()); prod_valid = 0; end
        if (f_psum) begin void'(psum_qu.pop_front()); psum_in_valid = 0; end
        if (f_sel) have_sel = 1;
        if (f_a0) begin have_a = 1; a_v = int'(sa0); end
        if (f_a1) begin have_a = 1; a_v = int'(sa1); end
        if (f_b0) begin have_b = 1; b_v = int'(sb0); end
        if (f_r) begin
          have_sel = 0; have_a = 0; have_b = 0; r_valid = 0;
        end else if (have_sel && have_a && have_b && !r_valid && !r_hold) begin
          if (r_wait < 0) r_wait = $urandom_range(0, 2);
          else if (r_wait > 0) r_wait--;
          if (r_wait == 0) begin
            r_valid = 1;
            r_data  = (WIDTH+2)'(a_v + b_v);
            r_wait  = -1;
          end
        end
      end
      sel_ready      = !have_sel && !sel_hold && rnd();
      a0_ready       = !have_a && !a0_hold && rnd();
      a1_ready       = !have_a && rnd();
      b0_ready       = !have_b && (b_force || rnd());
      psum_out_ready = !out_hold && rnd();
      if (!prod_valid && prod_qu.size() > 0 && rnd()) begin
        prod_valid = 1; prod_data = WIDTH'(prod_qu[0]);
      end
      if (!psum_in_valid && psum_qu.size() > 0 && rnd()) begin
        psum_in_valid = 1; psum_in_data = WIDTH'(psum_qu[0]);
      end
    end
  end

  // Reference model: what the adder must see and what the window must emit.
  task automatic push_window(input int p0, input int p1, input int p2, input int s);
    int p[NUM_MACS];
    int acc;
    p[0] = p0; p[1] = p1; p[2] = p2;
    acc = 0;
    for (int i = 0; i < NUM_MACS; i++) begin
      prod_qu.push_back(p[i]);
      exp_sel.push_back(1);
      exp_a0.push_back(acc);
      exp_b0.push_back(p[i]);
      if (acc + p[i] > 255) model_ovf = 1;
      acc = (acc + p[i]) % 256;
    end
    psum_qu.push_back(s);
    exp_sel.push_back(2);
    exp_a1.push_back(s);
    exp_b0.push_back(acc);
    exp_out.push_back(s + acc);
  endtask

  task automatic wait_outs();
    for (int i = 0; i < 2000 && out_log.size() < exp_out.size(); i++) @(negedge clk);
  endtask

  task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  task automatic compare_logs(input string tag);
    cmp_q({tag, "_sel"}, sel_log, exp_sel);
    cmp_q({tag, "_a0"},  a0_log,  exp_a0);
    cmp_q({tag, "_a1"},  a1_log,  exp_a1);
    cmp_q({tag, "_b0"},  b0_log,  exp_b0);
    cmp_q({tag, "_out"}, out_log, exp_out);
    check({tag, "_overflow"}, overflow, model_ovf);
    sel_log.delete(); a0_log.delete(); a1_log.delete(); b0_log.delete(); out_log.delete();
    exp_sel.delete(); exp_a0.delete(); exp_a1.delete(); exp_b0.delete(); exp_out.delete();
  endtask

  initial begin : main
    model_ovf = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_handshakes", {prod_ready, psum_in_ready, sel_valid, a0_valid, a1_valid,
                             b0_valid, r_ready, psum_out_valid}, 0);
    check("rst_data", {sel_data, a0_data, a1_data, b0_data} | 32'(psum_out_data), 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk); #1 rst_n = 1;

    // Basic window
    push_window(10, 20, 30, 5);
    wait_outs();
    compare_logs("basic");

    // SEL held off: request stays up and unchanged
    sel_hold = 1;
    push_window(3, 4, 5, 6);
    for (int i = 0; i < 100 && !sel_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("selhold_valid%0d", i), sel_valid, 1);
      check($sformatf("selhold_data%0d", i), sel_data, 1);
      @(negedge clk);
    end
    sel_hold = 0;
    wait_outs();
    compare_logs("selhold");

    // B0 taken first, A0 three cycles later
    a0_hold = 1; b_force = 1;
    push_window(7, 8, 9, 11);
    for (int i = 0; i < 100 && !a0_valid; i++) @(negedge clk);
    check("split_b0_offered", b0_valid, 1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("split_b0_dropped%0d", i), b0_valid, 0);
      check($sformatf("split_a0_held%0d", i), a0_valid, 1);
      check($sformatf("split_no_wait%0d", i), r_ready, 0);
      @(negedge clk);
    end
    a0_hold = 0; b_force = 0;
    wait_outs();
    compare_logs("split");

    // Accumulator overflow, truncated feedback
    push_window(200, 100, 0, 1);
    wait_outs();
    compare_logs("ovf");

    // Reset while waiting on the adder
    r_hold = 1;
    prod_qu.push_back(7);
    for (int i = 0; i < 100 && !r_ready; i++) @(negedge clk);
    check("midrst_in_wait", r_ready, 1);
    check("midrst_busy_before", busy, 1);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("midrst_handshakes", {sel_valid, a0_valid, a1_valid, b0_valid,
                                r_ready, psum_out_valid}, 0);
    check("midrst_busy", busy, 0);
    model_ovf = 0;
    check("midrst_overflow", overflow, model_ovf);
    r_hold = 0;
    sel_log.delete(); a0_log.delete(); a1_log.delete(); b0_log.delete(); out_log.delete();
    push_window(1, 2, 3, 4);
    wait_outs();
    compare_logs("midrst");

    // Result held off, then two windows back-to-back
    out_hold = 1;
    push_window(9, 9, 9, 9);
    for (int i = 0; i < 200 && !psum_out_valid; i++) @(negedge clk);
    push_window($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255));
    push_window($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("outhold_valid%0d", i), psum_out_valid, 1);
      check($sformatf("outhold_data%0d", i), psum_out_data, exp_out[0]);
      check($sformatf("outhold_prod_ready%0d", i), prod_ready, 0);
      @(negedge clk);
    end
    out_hold = 0;
    wait_outs();
    compare_logs("outhold");

    // Random windows
    for (int w = 0; w < 6; w++)
      push_window($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255));
    wait_outs();
    compare_logs("random");

    check("protocol_stability", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
